// File: rtl/issue_queue_entry_allocator.sv
// -----------------------------------------------------------------------------
// issue_queue_entry_allocator
//
// Free-list allocator for issue-queue entries. A circular buffer holds the
// indices of free entries: dispatch pops from head (up to DISPATCH_WIDTH per
// cycle), issue/flush pushes back at tail (up to RELEASE_WIDTH per cycle).
// The per-entry occupancy vector is published for row qualification.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   stall           blocks allocation this cycle (releases still proceed)
//   flush           returns every entry to the free list
//   allocReq        per-lane allocation request
//   allocPtr        per-lane assigned index (valid in the request cycle)
//   allocReady      at least DISPATCH_WIDTH entries free (registered)
//   releaseValid    per-lane release strobe
//   releasePtr      per-lane index being released
//   freeCount       number of free entries
//   entryValid      occupancy bit per entry
//   releaseError    sticky flag: some release was illegal
// -----------------------------------------------------------------------------
module issue_queue_entry_allocator #(
  parameter int ENTRY_NUM      = 16,
  parameter int INDEX_WIDTH    = $clog2(ENTRY_NUM),
  parameter int DISPATCH_WIDTH = 2,
  parameter int RELEASE_WIDTH  = 4,
  parameter int COUNT_WIDTH    = $clog2(ENTRY_NUM + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DISPATCH_WIDTH-1:0] allocReq,
  output logic [INDEX_WIDTH-1:0]    allocPtr [DISPATCH_WIDTH],
  output logic                      allocReady,
  input  logic [RELEASE_WIDTH-1:0]  releaseValid,
  input  logic [INDEX_WIDTH-1:0]    releasePtr [RELEASE_WIDTH],
  output logic [COUNT_WIDTH-1:0]    freeCount,
  output logic [ENTRY_NUM-1:0]      entryValid,
  output logic                      releaseError
);

  // Head/tail carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_WIDTH = INDEX_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0]   TAIL_RESET = PTR_WIDTH'(ENTRY_NUM);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(ENTRY_NUM);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] list_q [ENTRY_NUM];
  logic [INDEX_WIDTH-1:0] list_d [ENTRY_NUM];
  logic [PTR_WIDTH-1:0]   head_q, head_d;
  logic [PTR_WIDTH-1:0]   tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] free_count_q, free_count_d;
  logic [ENTRY_NUM-1:0]   entry_valid_q, entry_valid_d;
  logic                   release_error_q, release_error_d;

  // ---------------------------------------------------------------------------
  // Allocation lanes: lane k takes the free-list slot at head plus the number
  // of requesting lanes below it, so sparse request patterns stay packed.
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] alloc_offset [DISPATCH_WIDTH];
  logic [COUNT_WIDTH-1:0] n_alloc;
  logic                   alloc_ready;
  logic                   alloc_fire;

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      alloc_offset[k] = n_alloc[INDEX_WIDTH-1:0];
      n_alloc         = n_alloc + COUNT_WIDTH'(allocReq[k]);
    end
  end

  for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_alloc_lane
    logic [INDEX_WIDTH-1:0] slot;
    // Index arithmetic wraps naturally modulo ENTRY_NUM (power of two).
    assign slot          = head_q[INDEX_WIDTH-1:0] + alloc_offset[gi];
    assign allocPtr[gi]  = list_q[slot];
  end

  // Grant depends on registered state only; no path from req/stall/release.
  assign alloc_ready = (free_count_q >= COUNT_WIDTH'(DISPATCH_WIDTH));
  assign alloc_fire  = alloc_ready && !stall && !flush;

  // ---------------------------------------------------------------------------
  // Release legality: the entry must be occupied (registered view) and no
  // lower lane may carry the same index this cycle. An entry allocated in
  // this same cycle still reads as free here, so releasing it is illegal.
  // ---------------------------------------------------------------------------
  logic [RELEASE_WIDTH-1:0] rel_legal;
  logic [RELEASE_WIDTH-1:0] rel_illegal;

  for (genvar gi = 0; gi < RELEASE_WIDTH; gi++) begin : g_rel_lane
    logic dup;
    always_comb begin
      dup = 1'b0;
      for (int j = 0; j < gi; j++) begin
        if (releaseValid[j] && (releasePtr[j] == releasePtr[gi])) begin
          dup = 1'b1;
        end
      end
    end
    assign rel_legal[gi]   = releaseValid[gi] && entry_valid_q[releasePtr[gi]] && !dup;
    assign rel_illegal[gi] = releaseValid[gi] && !rel_legal[gi];
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] n_rel;
  logic [INDEX_WIDTH-1:0] rel_slot;

  always_comb begin
    list_d          = list_q;
    head_d          = head_q;
    entry_valid_d   = entry_valid_q;
    n_rel           = '0;
    rel_slot        = '0;
    // Error capture is independent of flush: flush never hides a bad release.
    release_error_d = release_error_q | (|rel_illegal);

    if (alloc_fire) begin
      head_d = head_q + PTR_WIDTH'(n_alloc);
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (allocReq[k]) begin
          entry_valid_d[allocPtr[k]] = 1'b1;
        end
      end
    end

    // Legal releases are appended at tail in ascending lane order. The write
    // window starting at tail never overlaps the allocation window at head
    // because the occupied count bounds the number of legal releases.
    for (int r = 0; r < RELEASE_WIDTH; r++) begin
      if (rel_legal[r]) begin
        rel_slot                      = tail_q[INDEX_WIDTH-1:0] + n_rel[INDEX_WIDTH-1:0];
        list_d[rel_slot]              = releasePtr[r];
        entry_valid_d[releasePtr[r]]  = 1'b0;
        n_rel                         = n_rel + COUNT_WIDTH'(1);
      end
    end

    tail_d       = tail_q + PTR_WIDTH'(n_rel);
    free_count_d = free_count_q - (alloc_fire ? n_alloc : '0) + n_rel;

    if (flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        list_d[i] = INDEX_WIDTH'(i);
      end
      head_d        = '0;
      tail_d        = TAIL_RESET;
      free_count_d  = COUNT_FULL;
      entry_valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        list_q[i] <= INDEX_WIDTH'(i);
      end
      head_q          <= '0;
      tail_q          <= TAIL_RESET;
      free_count_q    <= COUNT_FULL;
      entry_valid_q   <= '0;
      release_error_q <= 1'b0;
    end else begin
      list_q          <= list_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      free_count_q    <= free_count_d;
      entry_valid_q   <= entry_valid_d;
      release_error_q <= release_error_d;
    end
  end

  assign allocReady   = alloc_ready;
  assign freeCount    = free_count_q;
  assign entryValid   = entry_valid_q;
  assign releaseError = release_error_q;

  // The pointer distance is the free count; the two must never disagree.
  a_count_matches_ptrs : assert property (
    @(posedge clk) disable iff (rst)
      free_count_q == COUNT_WIDTH'(tail_q - head_q)
  );

endmodule

// File: tb/tb_issue_queue_entry_allocator.sv
module tb_issue_queue_entry_allocator;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int DW = 2;
  localparam int RW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic [DW-1:0] alloc_req;
  logic [IW-1:0] alloc_ptr [DW];
  logic          alloc_ready;
  logic [RW-1:0] rel_valid;
  logic [IW-1:0] rel_ptr [RW];
  logic [CW-1:0] free_count;
  logic [N-1:0]  entry_valid;
  logic          release_error;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a plain FIFO of free indices plus an occupancy set.
  int       free_q[$];
  bit [N-1:0] occ_m;
  bit       err_m;

  issue_queue_entry_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .allocReq     (alloc_req),
    .allocPtr     (alloc_ptr),
    .allocReady   (alloc_ready),
    .releaseValid (rel_valid),
    .releasePtr   (rel_ptr),
    .freeCount    (free_count),
    .entryValid   (entry_valid),
    .releaseError (release_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic void model_reset(bit keep_err);
    free_q.delete();
    for (int i = 0; i < N; i++) free_q.push_back(i);
    occ_m = '0;
    if (!keep_err) err_m = 1'b0;
  endfunction

  function automatic int exp_ptr(int k);
    int off = 0;
    for (int j = 0; j < k; j++) off += int'(alloc_req[j]);
    return (off < free_q.size()) ? free_q[off] : -1;
  endfunction

  function automatic void model_step();
    bit [N-1:0] seen = '0;
    int  rel_list[$];
    bit  fire;
    fire = (free_q.size() >= DW) && !stall && !flush;
    for (int r = 0; r < RW; r++) begin
      if (rel_valid[r]) begin
        if (occ_m[rel_ptr[r]] && !seen[rel_ptr[r]]) rel_list.push_back(int'(rel_ptr[r]));
        else err_m = 1'b1;
        seen[rel_ptr[r]] = 1'b1;
      end
    end
    if (flush) begin
      model_reset(1'b1);
      return;
    end
    if (fire) begin
      for (int k = 0; k < DW; k++) begin
        if (alloc_req[k]) begin
          occ_m[free_q[0]] = 1'b1;
          void'(free_q.pop_front());
        end
      end
    end
    foreach (rel_list[i]) begin
      free_q.push_back(rel_list[i]);
      occ_m[rel_list[i]] = 1'b0;
    end
  endfunction

  task automatic idle();
    stall     = 1'b0;
    flush     = 1'b0;
    alloc_req = '0;
    rel_valid = '0;
    for (int r = 0; r < RW; r++) rel_ptr[r] = '0;
  endtask

  // Advance one cycle: update the model with this cycle's inputs, then clock.
  task automatic tick();
    model_step();
    $display("cyc=%0d rst=%b stall=%b flush=%b req=%b relv=%b relp=%0d,%0d,%0d,%0d free=%0d",
             cyc, rst, stall, flush, alloc_req, rel_valid,
             rel_ptr[0], rel_ptr[1], rel_ptr[2], rel_ptr[3], free_count);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(1'b0);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset(1'b0);
    #1;
    n_cmp++; if (free_count !== CW'(16)) begin n_bad++; $display("FAIL reset_free: got %0d expected 16", free_count); end
    n_cmp++; if (entry_valid !== 16'h0000) begin n_bad++; $display("FAIL reset_valid: got %h expected 0000", entry_valid); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", alloc_ready); end
    n_cmp++; if (release_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", release_error); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 8; c++) begin
      idle();
      alloc_req = 2'b11;
      #1;
      n_cmp++; if (alloc_ptr[0] !== IW'(2 * c)) begin n_bad++; $display("FAIL fill_ptr0: got %0d expected %0d", alloc_ptr[0], 2 * c); end
      n_cmp++; if (alloc_ptr[1] !== IW'(2 * c + 1)) begin n_bad++; $display("FAIL fill_ptr1: got %0d expected %0d", alloc_ptr[1], 2 * c + 1); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (free_count !== CW'(0)) begin n_bad++; $display("FAIL fill_free: got %0d expected 0", free_count); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b expected 0", alloc_ready); end
    n_cmp++; if (entry_valid !== 16'hFFFF) begin n_bad++; $display("FAIL fill_valid: got %h expected FFFF", entry_valid); end
  endtask

  task automatic test_release_refill();
    idle();
    rel_valid = 4'b0011; rel_ptr[0] = 4'd5; rel_ptr[1] = 4'd9;
    tick();
    idle();
    alloc_req = 2'b11;
    #1;
    n_cmp++; if (free_count !== CW'(2)) begin n_bad++; $display("FAIL refill_free: got %0d expected 2", free_count); end
    n_cmp++; if (alloc_ptr[0] !== IW'(5)) begin n_bad++; $display("FAIL refill_ptr0: got %0d expected 5", alloc_ptr[0]); end
    n_cmp++; if (alloc_ptr[1] !== IW'(9)) begin n_bad++; $display("FAIL refill_ptr1: got %0d expected 9", alloc_ptr[1]); end
    tick();
    idle();
    #1;
    n_cmp++; if (free_count !== CW'(0)) begin n_bad++; $display("FAIL refill_free2: got %0d expected 0", free_count); end
  endtask

  task automatic test_alloc_and_release();
    idle();
    rel_valid = 4'b0011; rel_ptr[0] = 4'd0; rel_ptr[1] = 4'd1;
    tick();
    idle();
    alloc_req = 2'b11;
    rel_valid = 4'b0111; rel_ptr[0] = 4'd2; rel_ptr[1] = 4'd3; rel_ptr[2] = 4'd4;
    #1;
    n_cmp++; if (alloc_ptr[0] !== IW'(0)) begin n_bad++; $display("FAIL same_ptr0: got %0d expected 0", alloc_ptr[0]); end
    n_cmp++; if (alloc_ptr[1] !== IW'(1)) begin n_bad++; $display("FAIL same_ptr1: got %0d expected 1", alloc_ptr[1]); end
    tick();
    idle();
    alloc_req = 2'b11;
    #1;
    n_cmp++; if (free_count !== CW'(3)) begin n_bad++; $display("FAIL same_free: got %0d expected 3", free_count); end
    n_cmp++; if (entry_valid !== 16'hFFE3) begin n_bad++; $display("FAIL same_valid: got %h expected FFE3", entry_valid); end
    n_cmp++; if (alloc_ptr[0] !== IW'(2)) begin n_bad++; $display("FAIL same_next0: got %0d expected 2", alloc_ptr[0]); end
    n_cmp++; if (alloc_ptr[1] !== IW'(3)) begin n_bad++; $display("FAIL same_next1: got %0d expected 3", alloc_ptr[1]); end
    tick();
    idle();
  endtask

  task automatic test_sparse_stall();
    idle();
    flush = 1'b1;
    tick();
    idle();
    alloc_req = 2'b10;
    #1;
    n_cmp++; if (alloc_ptr[1] !== IW'(0)) begin n_bad++; $display("FAIL sparse_ptr: got %0d expected 0", alloc_ptr[1]); end
    tick();
    idle();
    alloc_req = 2'b10;
    #1;
    n_cmp++; if (free_count !== CW'(15)) begin n_bad++; $display("FAIL sparse_free: got %0d expected 15", free_count); end
    n_cmp++; if (alloc_ptr[1] !== IW'(1)) begin n_bad++; $display("FAIL sparse_head: got %0d expected 1", alloc_ptr[1]); end
    n_cmp++; if (entry_valid !== 16'h0001) begin n_bad++; $display("FAIL sparse_valid: got %h expected 0001", entry_valid); end
    idle();
    flush = 1'b1;
    tick();
    idle();
    stall = 1'b1;
    alloc_req = 2'b10;
    tick();
    idle();
    #1;
    n_cmp++; if (free_count !== CW'(16)) begin n_bad++; $display("FAIL stall_free: got %0d expected 16", free_count); end
    n_cmp++; if (entry_valid !== 16'h0000) begin n_bad++; $display("FAIL stall_valid: got %h expected 0000", entry_valid); end
  endtask

  task automatic test_errors();
    idle();
    sync_reset();
    alloc_req = 2'b11;
    tick();
    idle();
    rel_valid = 4'b0101; rel_ptr[0] = 4'd1; rel_ptr[2] = 4'd1;
    tick();
    idle();
    #1;
    n_cmp++; if (release_error !== 1'b1) begin n_bad++; $display("FAIL dup_err: got %b expected 1", release_error); end
    n_cmp++; if (free_count !== CW'(15)) begin n_bad++; $display("FAIL dup_free: got %0d expected 15", free_count); end
    n_cmp++; if (entry_valid !== 16'h0001) begin n_bad++; $display("FAIL dup_valid: got %h expected 0001", entry_valid); end
    sync_reset();
    #1;
    n_cmp++; if (release_error !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b expected 0", release_error); end
    rel_valid = 4'b0001; rel_ptr[0] = 4'd7;
    tick();
    idle();
    #1;
    n_cmp++; if (release_error !== 1'b1) begin n_bad++; $display("FAIL free_rel_err: got %b expected 1", release_error); end
    n_cmp++; if (free_count !== CW'(16)) begin n_bad++; $display("FAIL free_rel_count: got %0d expected 16", free_count); end
    alloc_req = 2'b11;
    tick();
    idle();
    flush = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (release_error !== 1'b1) begin n_bad++; $display("FAIL flush_err: got %b expected 1", release_error); end
    n_cmp++; if (free_count !== CW'(16)) begin n_bad++; $display("FAIL flush_free: got %0d expected 16", free_count); end
    n_cmp++; if (entry_valid !== 16'h0000) begin n_bad++; $display("FAIL flush_valid: got %h expected 0000", entry_valid); end
  endtask

  task automatic test_async_reset();
    idle();
    rel_valid = 4'b0001; rel_ptr[0] = 4'd3;
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      alloc_req = 2'b11;
      tick();
    end
    idle();
    #1;
    n_cmp++; if (free_count !== CW'(6)) begin n_bad++; $display("FAIL pre_async_free: got %0d expected 6", free_count); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (free_count !== CW'(16)) begin n_bad++; $display("FAIL async_free: got %0d expected 16", free_count); end
    n_cmp++; if (entry_valid !== 16'h0000) begin n_bad++; $display("FAIL async_valid: got %h expected 0000", entry_valid); end
    n_cmp++; if (release_error !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b expected 0", release_error); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL async_ready: got %b expected 1", alloc_ready); end
    #2;
    rst = 1'b0;
    model_reset(1'b0);
    @(negedge clk);
    alloc_req = 2'b11;
    #1;
    n_cmp++; if (alloc_ptr[0] !== IW'(0)) begin n_bad++; $display("FAIL post_async_ptr0: got %0d expected 0", alloc_ptr[0]); end
    n_cmp++; if (alloc_ptr[1] !== IW'(1)) begin n_bad++; $display("FAIL post_async_ptr1: got %0d expected 1", alloc_ptr[1]); end
    tick();
    idle();
  endtask

  task automatic test_random();
    int occ_list[$];
    int e;
    for (int c = 0; c < 400; c++) begin
      idle();
      stall     = ($urandom_range(7) == 0);
      flush     = ($urandom_range(31) == 0);
      alloc_req = DW'($urandom);
      occ_list.delete();
      for (int i = 0; i < N; i++) if (occ_m[i]) occ_list.push_back(i);
      for (int r = 0; r < RW; r++) begin
        rel_valid[r] = ($urandom_range(1) == 1);
        if (occ_list.size() > 0 && $urandom_range(3) != 0)
          rel_ptr[r] = IW'(occ_list[$urandom_range(occ_list.size() - 1)]);
        else
          rel_ptr[r] = IW'($urandom_range(N - 1));
      end
      #1;
      n_cmp++; if (free_count !== CW'(free_q.size())) begin n_bad++; $display("FAIL rnd_free: cyc %0d got %0d expected %0d", cyc, free_count, free_q.size()); end
      n_cmp++; if (alloc_ready !== (free_q.size() >= DW)) begin n_bad++; $display("FAIL rnd_ready: cyc %0d got %b expected %b", cyc, alloc_ready, free_q.size() >= DW); end
      n_cmp++; if (entry_valid !== occ_m) begin n_bad++; $display("FAIL rnd_valid: cyc %0d got %h expected %h", cyc, entry_valid, occ_m); end
      n_cmp++; if (release_error !== err_m) begin n_bad++; $display("FAIL rnd_err: cyc %0d got %b expected %b", cyc, release_error, err_m); end
      if (free_q.size() >= DW) begin
        for (int k = 0; k < DW; k++) begin
          if (alloc_req[k]) begin
            e = exp_ptr(k);
            n_cmp++; if (alloc_ptr[k] !== IW'(e)) begin n_bad++; $display("FAIL rnd_ptr%0d: cyc %0d got %0d expected %0d", k, cyc, alloc_ptr[k], e); end
          end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_release_refill();
    test_alloc_and_release();
    test_sparse_stall();
    test_errors();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
